prbs5_checker: RTL
==================

// Module: prbs5_checker
// PURPOSE
//  Receive-side partner of the 5-bit LFSR generator: checks a serial bit stream against
//  the sequence x^5+x^3+1 (new bit = s[4]^s[2], shift left, period 31).
//  Self-synchronises, reports lock, per-bit errors, a saturating error count and loss-of-lock.
//  Sits at the far end of a link or test path that carries the generator's new bit each cycle.
// PARAMETERS
//  VERIFY_LEN  10  consecutive correct predictions required in VERIFY before LOCKED
//  WIN_LEN     31  LOCKED-state window length, in valid bits
//  LOL_THRESH  4   errors within one window that force loss of lock
//  CNT_W       16  width of err_cnt
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  din_valid  in   1      din is sampled only when 1
//  din        in   1      received PRBS bit
//  clr_cnt    in   1      synchronous clear of err_cnt (and err_sticky)
//  locked     out  1      1 while in LOCKED
//  err_pulse  out  1      1-cycle pulse: mismatch on a bit checked in LOCKED
//  lol_pulse  out  1      1-cycle pulse: LOCKED -> HUNT transition
//  err_cnt    out  CNT_W  saturating count of LOCKED-state mismatches
//  err_sticky out  1      only with PRBS5_CHK_STICKY_EN
// BEHAVIOUR
//  - Reset: state=HUNT, s=0, fill=0, all counters 0; locked, err_pulse, lol_pulse,
//    err_cnt, err_sticky = 0. All outputs are registered.
//  - No state changes on cycles with din_valid=0; pulses last exactly one clk.
//  - exp = s[4]^s[2]; mismatch = din ^ exp (evaluated only on a valid bit).
//  - HUNT: s <= {s[3:0],din}; fill increments to 5. When fill reaches 5 and the next s != 0,
//    go to VERIFY. If s==0 (lock-up pattern), stay in HUNT and keep shifting.
//  - VERIFY: s <= {s[3:0],din}. A match increments vcnt; vcnt==VERIFY_LEN goes to LOCKED.
//    A mismatch clears vcnt and fill and returns to HUNT. No err_cnt activity.
//  - Lock latency on a clean stream: locked=1 on the cycle after the 15th valid bit (5+VERIFY_LEN).
//  - LOCKED: s <= {s[3:0],exp}, i.e. the prediction is shifted in, not din (flywheel).
//    On mismatch: err_pulse=1 next cycle; err_cnt+1 saturating at 2^CNT_W-1; werr+1.
//    wcnt counts valid bits 0..WIN_LEN-1; at the wrap, wcnt=0 and werr=0.
//    If werr reaches LOL_THRESH (including the current bit), next state is HUNT with
//    fill=0 and vcnt=0; lol_pulse=1 and locked=0 on the same next cycle. This has
//    priority over a window wrap on the same bit.
//  - clr_cnt has priority over the stored value, but a mismatch on the same cycle is still
//    counted: err_cnt becomes 1. clr_cnt does not affect state or lock.
//  - err_cnt is retained across loss of lock; it is cleared only by reset or clr_cnt.
//  - Reset asserted mid-operation returns everything to reset values immediately.
// CONFIGURATION
//  PRBS5_CHK_STICKY_EN defined:
//    - err_sticky is set on any LOCKED mismatch or lol event and cleared only by
//      clr_cnt or reset.
//    - set wins over a simultaneous clr_cnt.
//  Undefined: the err_sticky port and its logic are absent; all else is identical.
// STRUCTURE
//  - prbs5_pkg: LFSR_W=5, TAP_HI=4, TAP_LO=2, PRBS_PERIOD=31, and the state enum
//    {HUNT, VERIFY, LOCKED} as 2-bit localparams.
//  - Sub-module prbs5_lol_monitor: wcnt/werr window logic.
//    Inputs: bit strobe, mismatch, enable. Output: lol request.
//  - The top holds the shift register, FSM and err_cnt.
// TESTING
//  1. Reset held, din toggling -> locked=0, err_cnt=0, no pulses; release -> state HUNT.
//  2. Clean stream from seed 5'b11100, din_valid=1 -> locked=1 after 15 bits;
//     200 more bits -> err_cnt=0.
//  3. After lock, flip one bit -> single err_pulse, err_cnt=1, locked stays 1,
//     subsequent clean bits give no errors.
//  4. After lock, flip 4 bits within 31 -> lol_pulse on the 4th, locked=0;
//     clean bits -> relock after 15; err_cnt=4 retained.
//  5. All-zero input for 100 bits -> never leaves HUNT.
//     Clean stream with din_valid gaps of 1-3 cycles -> lock after 15 valid bits.
//  6. clr_cnt on the same cycle as a mismatch with err_cnt=7 -> err_cnt=1;
//     with STICKY_EN, err_sticky=1 and cleared by a later clr_cnt alone.

Source files
------------

// File: rtl/prbs5_pkg.sv
// Shared constants and FSM encoding for the PRBS5 (x^5+x^3+1) receive checker.
package prbs5_pkg;

    localparam int unsigned LFSR_W      = 5;
    localparam int unsigned TAP_HI      = 4;
    localparam int unsigned TAP_LO      = 2;
    localparam int unsigned PRBS_PERIOD = 31;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/prbs5_lol_monitor.sv
// Windowed error counter for the PRBS5 checker: requests loss of lock when too
// many mismatches land inside one WIN_LEN-bit window while locked.
module prbs5_lol_monitor #(
    parameter int unsigned WIN_LEN    = 31,
    parameter int unsigned LOL_THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_stb,
    input  logic mismatch,
    input  logic en,
    output logic lol_req_c
);

    localparam int unsigned WCNT_W = $clog2(WIN_LEN + 1);
    localparam int unsigned WERR_W = $clog2(LOL_THRESH + 1);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [WERR_W-1:0] werr_q, werr_d;
    logic [WERR_W-1:0] werr_inc_c;

    // The current bit counts toward the threshold before any window wrap.
    assign werr_inc_c = werr_q + WERR_W'(mismatch);
    assign lol_req_c  = en & bit_stb & mismatch & (werr_inc_c >= WERR_W'(LOL_THRESH));

    always_comb begin
        wcnt_d = wcnt_q;
        werr_d = werr_q;
        if (!en || lol_req_c) begin
            wcnt_d = '0;
            werr_d = '0;
        end else if (bit_stb) begin
            if (wcnt_q == WCNT_W'(WIN_LEN - 1)) begin
                wcnt_d = '0;
                werr_d = '0;
            end else begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                werr_d = werr_inc_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= '0;
            werr_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            werr_q <= werr_d;
        end
    end

endmodule

// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS5 (x^5+x^3+1) stream checker with lock, error count and LOL.
// Optional err_sticky output enabled by defining PRBS5_CHK_STICKY_EN.
module prbs5_checker
    import prbs5_pkg::*;
#(
    parameter int unsigned VERIFY_LEN = 10,
    parameter int unsigned WIN_LEN    = PRBS_PERIOD,
    parameter int unsigned LOL_THRESH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             lol_pulse,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRBS5_CHK_STICKY_EN
    ,
    output logic             err_sticky
`endif
);

    localparam int unsigned VCNT_W = $clog2(VERIFY_LEN + 1);
    localparam int unsigned FILL_W = $clog2(LFSR_W + 1);

    state_e             state_q, state_d;
    logic [LFSR_W-1:0]  s_q, s_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               lol_pulse_q, lol_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic exp_c, mismatch_c, mon_en_c, lock_err_c, lol_req_c;

    assign exp_c      = s_q[TAP_HI] ^ s_q[TAP_LO];
    assign mismatch_c = din ^ exp_c;
    assign mon_en_c   = (state_q == LOCKED);
    assign lock_err_c = din_valid & mon_en_c & mismatch_c;

    prbs5_lol_monitor #(
        .WIN_LEN    (WIN_LEN),
        .LOL_THRESH (LOL_THRESH)
    ) u_lol_mon (
        .clk       (clk),
        .rst       (rst),
        .bit_stb   (din_valid),
        .mismatch  (mismatch_c),
        .en        (mon_en_c),
        .lol_req_c (lol_req_c)
    );

    // Sync FSM; in LOCKED the register flywheels on its own prediction.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        fill_d  = fill_q;
        vcnt_d  = vcnt_q;
        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    s_d = {s_q[LFSR_W-2:0], din};
                    if (fill_q != FILL_W'(LFSR_W)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                    if (fill_d == FILL_W'(LFSR_W) && s_d != '0) begin
                        state_d = VERIFY;
                        vcnt_d  = '0;
                    end
                end
                VERIFY: begin
                    s_d = {s_q[LFSR_W-2:0], din};
                    if (mismatch_c) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        vcnt_d  = '0;
                    end else begin
                        vcnt_d = vcnt_q + VCNT_W'(1);
                        if (vcnt_d == VCNT_W'(VERIFY_LEN)) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    s_d = {s_q[LFSR_W-2:0], exp_c};
                    if (lol_req_c) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        vcnt_d  = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output strobes and the saturating error counter; clear still counts a same-cycle error.
    always_comb begin
        locked_d    = (state_d == LOCKED);
        err_pulse_d = lock_err_c;
        lol_pulse_d = lol_req_c;
        err_cnt_d   = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = lock_err_c ? CNT_W'(1) : '0;
        end else if (lock_err_c && err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            s_q         <= '0;
            fill_q      <= '0;
            vcnt_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lol_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            vcnt_q      <= vcnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            lol_pulse_q <= lol_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign lol_pulse = lol_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef PRBS5_CHK_STICKY_EN
    logic sticky_q, sticky_d;

    // Set beats a simultaneous clear so no event is ever lost.
    always_comb begin
        sticky_d = sticky_q;
        if (lock_err_c || lol_req_c) begin
            sticky_d = 1'b1;
        end else if (clr_cnt) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign err_sticky = sticky_q;
`endif

endmodule
